// File: rtl/lzd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lzd_pkg
//  Brief    : Shared widths and constants for the shared LZD/normaliser block
//  Revision : 1.0 - initial release
// ============================================================================
package lzd_pkg;

  localparam int DATA_W = 48;
  localparam int LZ_W   = 6;
  localparam int TAG_W  = 2;

  // Count reported for an all-zero operand
  localparam logic [LZ_W-1:0] LZ_ZERO = 6'd48;

  // Requester identities as carried in out_src and the round-robin pointer
  localparam logic SRC_LOG  = 1'b0;
  localparam logic SRC_SQRT = 1'b1;

endpackage : lzd_pkg
`default_nettype wire

// File: rtl/lzd_norm_arbiter_lzd.sv
`default_nettype none
// ============================================================================
//  Module   : lzd_norm_arbiter_lzd
//  Brief    : Combinational leading-zero detector. Count = DATA_W-1 minus the
//             index of the highest set bit, DATA_W when the operand is zero.
//  Revision : 1.0 - initial release
// ============================================================================
module lzd_norm_arbiter_lzd
  import lzd_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int LZ_W_P   = LZ_W
) (
  input  logic                en,
  input  logic [DATA_W_P-1:0] data,
  output logic [LZ_W_P-1:0]   lz,
  output logic                zero
);

  // Scan upward so the highest set bit is the last one to write the count
  always_comb begin
    lz   = '0;
    zero = 1'b0;
    if (en) begin
      lz   = LZ_W_P'(DATA_W_P);
      zero = 1'b1;
      for (int i = 0; i < DATA_W_P; i++) begin
        if (data[i]) begin
          lz   = LZ_W_P'(DATA_W_P - 1 - i);
          zero = 1'b0;
        end
      end
    end
  end

endmodule : lzd_norm_arbiter_lzd
`default_nettype wire

// File: rtl/lzd_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lzd_norm_arbiter
//  Brief    : Round-robin shares one 48-bit LZD + left-shift normaliser between
//             the log path (req0) and the sqrt path (req1). Two-stage pipeline:
//             operand register S1 and result register S2, valid/ready on both
//             sides, capacity two operands.
//  Revision : 1.0 - initial release
// ============================================================================
module lzd_norm_arbiter
  import lzd_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,   // only 48 is supported
  parameter int LZ_W_P   = LZ_W,
  parameter int TAG_W_P  = TAG_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  input  logic [DATA_W_P-1:0] req0_data,
  input  logic [TAG_W_P-1:0]  req0_tag,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [DATA_W_P-1:0] req1_data,
  input  logic [TAG_W_P-1:0]  req1_tag,
  output logic                req1_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_src,
  output logic [TAG_W_P-1:0]  out_tag,
  output logic [LZ_W_P-1:0]   out_lz,
  output logic [DATA_W_P-1:0] out_norm,
  output logic                out_zero
);

  // Operand stage
  logic                s1_v;
  logic [DATA_W_P-1:0] s1_data;
  logic [TAG_W_P-1:0]  s1_tag;
  logic                s1_src;

  // Round-robin pointer: source of the most recently accepted operand
  logic last;

  logic                s2_load;
  logic                s1_free;
  logic                grant;
  logic                accept;
  logic [LZ_W_P-1:0]   lz_cnt;
  logic                lz_zero;
  logic [DATA_W_P-1:0] norm_val;

  assign s2_load = s1_v && (!out_valid || out_ready);
  assign s1_free = !s1_v || s2_load;

  // Grant: a lone requester wins; on contention the one not served last wins.
  // With nobody requesting, the grant parks on the requester due next.
  always_comb begin
    grant = ~last;
    if (req0_valid && req1_valid) begin
      grant = ~last;
    end else if (req0_valid) begin
      grant = SRC_LOG;
    end else if (req1_valid) begin
      grant = SRC_SQRT;
    end
  end

  // Readies are gated by reset so nothing is accepted while reset is held
  assign req0_ready = reset_n && s1_free && (grant == SRC_LOG);
  assign req1_ready = reset_n && s1_free && (grant == SRC_SQRT);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // S1 capture and round-robin update; the pointer moves only on a transfer
  // so a stalled grant is never rotated away from its waiting requester
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_tag  <= '0;
      s1_src  <= SRC_LOG;
      last    <= SRC_SQRT;
    end else begin
      if (accept) begin
        s1_v    <= 1'b1;
        s1_data <= (grant == SRC_SQRT) ? req1_data : req0_data;
        s1_tag  <= (grant == SRC_SQRT) ? req1_tag  : req0_tag;
        s1_src  <= grant;
        last    <= grant;
      end else if (s2_load) begin
        s1_v    <= 1'b0;
      end
    end
  end

  lzd_norm_arbiter_lzd #(
    .DATA_W_P (DATA_W_P),
    .LZ_W_P   (LZ_W_P)
  ) u_lzd (
    .en   (1'b1),
    .data (s1_data),
    .lz   (lz_cnt),
    .zero (lz_zero)
  );

  // A zero operand reports count DATA_W, so the shift already yields zero;
  // the explicit select keeps the result independent of shift-overflow rules
  assign norm_val = lz_zero ? '0 : (s1_data << lz_cnt);

  // Result register: loads from S1 when free or draining, otherwise holds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_src   <= SRC_LOG;
      out_tag   <= '0;
      out_lz    <= '0;
      out_norm  <= '0;
      out_zero  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_src   <= s1_src;
      out_tag   <= s1_tag;
      out_lz    <= lz_cnt;
      out_norm  <= norm_val;
      out_zero  <= lz_zero;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : lzd_norm_arbiter
`default_nettype wire
